// File: rtl/stepper_phase_decoder.sv
// Receive-side decoder for the 4-phase one-cold stepper drive on the railway gate.
// Recovers step pulses, direction, gate position, limits, motion status and a sticky error.
module stepper_phase_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 12,
  parameter int MAX_POS     = 1024,
  parameter int IDLE_CYC    = 65536
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       phase_in,
  input  logic             clr_err,
  input  logic             pos_clr,
  output logic [POS_W-1:0] position,
  output logic             step_fwd,
  output logic             step_rev,
  output logic             dir,
  output logic             gate_closed,
  output logic             gate_open,
  output logic             moving,
  output logic             err
);

  localparam int                IDLE_W   = $clog2(IDLE_CYC + 1);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(MAX_POS);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYC);

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CAPTURE,
    EV_FWD,
    EV_REV,
    EV_BAD,
    EV_SKIP
  } event_e;

  logic [3:0]             sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [3:0]             s;
  logic                   s_live;
  logic                   s_valid;

  logic [3:0]        prev_q, prev_nxt;
  logic              prev_valid_q, prev_valid_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic              dir_nxt;
  logic              err_set;
  logic [IDLE_W-1:0] idle_q, idle_nxt;
  event_e            ev;

  // fill_q tracks which synchroniser stages hold a real sample rather than the
  // 1111 reset filler, so the filler draining out is never reported as an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchroniser array is reset explicitly; a memory-style array
      // only gets a reset value when each element is assigned in the reset branch.
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b1111;
      fill_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0] <= phase_in;
      fill_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
        fill_q[i] <= fill_q[i-1];
      end
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign s_live = fill_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    s_valid        = (s == 4'b0111) || (s == 4'b1011) || (s == 4'b1101) || (s == 4'b1110);
    ev             = EV_NONE;
    prev_nxt       = prev_q;
    prev_valid_nxt = prev_valid_q;
    pos_nxt        = position;
    dir_nxt        = dir;
    err_set        = 1'b0;

    if (!s_valid)                               ev = s_live ? EV_BAD : EV_NONE;
    else if (!prev_valid_q)                     ev = EV_CAPTURE;
    else if (s == prev_q)                       ev = EV_NONE;
    else if (s == {prev_q[0], prev_q[3:1]})     ev = EV_FWD;
    else if (s == {prev_q[2:0], prev_q[3]})     ev = EV_REV;
    else                                        ev = EV_SKIP;

    case (ev)
      EV_CAPTURE: begin
        prev_nxt       = s;
        prev_valid_nxt = 1'b1;
      end
      EV_FWD: begin
        prev_nxt = s;
        dir_nxt  = 1'b1;
        if (position < POS_MAX) pos_nxt = position + 1'b1;
      end
      EV_REV: begin
        prev_nxt = s;
        dir_nxt  = 1'b0;
        if (position != '0) pos_nxt = position - 1'b1;
      end
      EV_BAD:  err_set = 1'b1;
      EV_SKIP: begin
        err_set  = 1'b1;
        prev_nxt = s;
      end
      default: ;
    endcase

    if (pos_clr) pos_nxt = '0;

    if (ev == EV_FWD || ev == EV_REV) idle_nxt = '0;
    else if (idle_q == IDLE_MAX)      idle_nxt = idle_q;
    else                              idle_nxt = idle_q + 1'b1;
  end

  // Idle counter resets to its saturated value so moving stays low until the first step.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      position     <= '0;
      step_fwd     <= 1'b0;
      step_rev     <= 1'b0;
      dir          <= 1'b0;
      gate_closed  <= 1'b1;
      gate_open    <= 1'b0;
      moving       <= 1'b0;
      err          <= 1'b0;
      idle_q       <= IDLE_MAX;
    end else begin
      prev_q       <= prev_nxt;
      prev_valid_q <= prev_valid_nxt;
      position     <= pos_nxt;
      step_fwd     <= (ev == EV_FWD);
      step_rev     <= (ev == EV_REV);
      dir          <= dir_nxt;
      gate_closed  <= (pos_nxt == '0);
      gate_open    <= (pos_nxt == POS_MAX);
      moving       <= (idle_nxt < IDLE_MAX);
      err          <= err_set | (err & ~clr_err);
      idle_q       <= idle_nxt;
    end
  end

endmodule

// File: doc/stepper_phase_decoder.md
Name: stepper_phase_decoder

Overview:
Receive-side monitor for the 4-phase stepper drive that operates the railway gate. Samples the one-cold phase pattern on the motor coil lines and recovers step events, direction and an absolute gate position count. Flags illegal patterns and skipped phases, and reports gate open/closed limits and motion status to the gate controller. Sits between the coil lines, or a feedback tap of them, and the gate supervisory logic.

Parameters:
SYNC_STAGES, 2, flops in the input synchroniser on phase_in (min 2)
POS_W, 12, width of position counter
MAX_POS, 1024, step count at which the gate is fully open; position saturates here
IDLE_CYC, 65536, clk cycles without a step before moving deasserts

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
phase_in  input  4  coil phase pattern; valid values 0111, 1011, 1101, 1110
clr_err  input  1  clears err (single-cycle pulse)
pos_clr  input  1  homing: forces position to 0
position  output  POS_W  step count, 0 = closed
step_fwd  output  1  one-cycle pulse per forward step
step_rev  output  1  one-cycle pulse per reverse step
dir  output  1  direction of last valid step; 1 = forward/opening
gate_closed  output  1  position == 0
gate_open  output  1  position == MAX_POS
moving  output  1  a step occurred within the last IDLE_CYC cycles
err  output  1  sticky: illegal pattern or skipped phase seen

Behaviour:
- Reset is synchronous, active-high, and applies to clk only. On reset: position=0, step_fwd=0, step_rev=0, dir=0, gate_closed=1, gate_open=0, moving=0, err=0.
- On reset, the synchroniser flops load 1111. The prev-pattern register is cleared and prev_valid=0.
- phase_in passes through SYNC_STAGES flops. The synchronised value is s.
- Every cycle, compare s with prev.
  - Valid: s has exactly one 0 bit.
  - Forward step: s == rotate-right(prev), i.e. {prev[0],prev[3],prev[2],prev[1]}. Sequence 0111 -> 1011 -> 1101 -> 1110 -> 0111.
  - Reverse step: s == rotate-left(prev), i.e. {prev[2],prev[1],prev[0],prev[3]}. Sequence 0111 -> 1110 -> 1101 -> 1011 -> 0111.
- Decision per cycle, in priority order:
  1. s invalid (0000, 1111, or two or more zeros): set err. prev is unchanged. No step.
  2. prev_valid=0 and s valid: prev=s, prev_valid=1. No step and no error; this is the first capture after reset.
  3. s == prev: no action.
  4. Forward step: prev=s, one-cycle step_fwd pulse, dir=1, position+1 saturating at MAX_POS.
  5. Reverse step: prev=s, one-cycle step_rev pulse, dir=0, position-1 saturating at 0.
  6. Otherwise (opposite phase, i.e. a two-step skip): set err, prev=s to resync. No step, position unchanged.
- All outputs are registered. A phase_in change appears on step_fwd/step_rev/position exactly SYNC_STAGES+1 cycles later.
- Step pulses are emitted even when position is saturated. Saturation does not set err.
- gate_closed and gate_open are derived from the registered position and update in the same cycle as position.
- pos_clr takes priority over a step in the same cycle: position=0. The step pulse and dir still update, and prev still advances.
- clr_err clears err. If clr_err coincides with a new error condition, the set wins and err stays 1.
- moving is driven by an idle counter.
  - The counter is reset to 0 on every step pulse and otherwise increments, saturating at IDLE_CYC.
  - moving=1 while counter < IDLE_CYC.
  - moving asserts in the same cycle as the first step pulse.
- Reset asserted mid-motion returns all state to reset values. The next valid pattern is a fresh capture and is not counted.

Test Plan:
- Reset, hold phase_in=0111 then step forward 0111->1011->1101->1110->0111, each held 8 cycles -> first 0111 is capture only; 4 step_fwd pulses each SYNC_STAGES+1 cycles after its change; position=4; dir=1; err=0; gate_closed falls with the first step.
- From position 4, apply reverse sequence 0111->1110->1101->1011 -> 3 step_rev pulses; position=1; dir=0.
- MAX_POS=8: drive 10 forward steps -> position saturates at 8 with gate_open=1; 10 step_fwd pulses; err=0. Then 10 reverse steps -> position=0, gate_closed=1.
- Inject 1111, then a skip 0111->1101 -> err=1 with no count change; the following 1110 counts as a forward step from 1101; clr_err coinciding with an injected 0011 leaves err=1; clr_err alone clears it.
- pos_clr asserted in the same cycle as a forward step at position 5 -> position=0, step_fwd=1, dir=1.
- IDLE_CYC=16: one step then hold the pattern -> moving=1 for exactly 16 cycles then 0; assert rst mid-sequence -> all outputs at reset values, and the next valid pattern produces no step pulse.
